// File: rtl/mips_data_mem_responder.sv
// mips_data_mem_responder: word-organized data memory responder for the multicycle MIPS core data port
module mips_data_mem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1001_0000,
   parameter int DEPTH_WORDS = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,
   output logic [15:0]           access_count
);
   localparam int IW = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state;
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic [ADDR_WIDTH-1:0] offset;
   logic borrow, legal, we_q, legal_q;
   logic [IW-1:0] idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   assign {borrow, offset} = {1'b0, req_addr} - {1'b0, BASE_ADDR};
   assign legal = !borrow && (req_addr[1:0] | offset[1:0]) == 2'b00 && offset[ADDR_WIDTH-1:IW+2] == '0;
   assign req_ready = state == IDLE;
   assign rsp_valid = state == RESP;
   assign busy = state != IDLE;
   // request FSM: capture on accept, read in ACCESS, respond and count in RESP
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         we_q <= 1'b0;
         legal_q <= 1'b0;
         idx_q <= '0;
         wdata_q <= '0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
         access_count <= '0;
      end else
         case (state)
            IDLE: if (req_valid) begin
               state <= ACCESS;
               we_q <= req_we;
               legal_q <= legal;
               idx_q <= offset[IW+1:2];
               wdata_q <= req_wdata;
            end
            ACCESS: begin
               state <= RESP;
               rsp_rdata <= legal_q && !we_q ? mem[idx_q] : '0;
               rsp_err <= !legal_q;
            end
            RESP: begin
               state <= IDLE;
               rsp_rdata <= '0;
               rsp_err <= 1'b0;
               if (!rsp_err && access_count != 16'hFFFF) access_count <= access_count + 16'd1;
            end
            default: state <= IDLE;
         endcase
   // store commits on the edge leaving ACCESS; an aborting reset has already forced IDLE
   always_ff @(posedge clk)
      if (state == ACCESS && legal_q && we_q) mem[idx_q] <= wdata_q;
endmodule

// File: tb/tb_mips_data_mem_responder.sv
// tb_mips_data_mem_responder: table-driven check of the data memory responder plus multi-cycle corner sequences
module tb_mips_data_mem_responder;
   logic clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata;
   logic req_ready, rsp_valid, rsp_err, busy;
   logic [15:0] access_count;
   int checks = 0, errs = 0;

   typedef struct {
      logic we;
      logic [31:0] addr, wdata, rdata;
      logic err;
      logic [15:0] cnt;
   } vec_t;
   vec_t tv[17];

   mips_data_mem_responder dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy), .access_count(access_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic err, input logic [15:0] cnt);
      @(negedge clk);
      chk("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we = we;
      req_addr = addr;
      req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      req_we = ~we;
      req_addr = $urandom;
      req_wdata = $urandom;
      chk("access_busy", {30'd0, busy, req_ready}, 32'd2);
      chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("resp_valid", 32'(rsp_valid), 32'd1);
      chk("resp_rdata", rsp_rdata, rdata);
      chk("resp_err", 32'(rsp_err), 32'(err));
      @(negedge clk);
      chk("post_idle", {29'd0, rsp_valid, rsp_err, req_ready}, 32'd1);
      chk("post_rdata", rsp_rdata, 32'd0);
      chk("access_count", 32'(access_count), 32'(cnt));
   endtask

   initial begin
      int pulses;
      tv[0]  = '{1'b1, 32'h1001_0000, 32'h0000_002C, 32'h0000_0000, 1'b0, 16'd1};
      tv[1]  = '{1'b0, 32'h1001_0000, 32'h0000_0000, 32'h0000_002C, 1'b0, 16'd2};
      tv[2]  = '{1'b1, 32'h1001_0004, 32'h0000_002E, 32'h0000_0000, 1'b0, 16'd3};
      tv[3]  = '{1'b1, 32'h1001_0008, 32'h0000_0020, 32'h0000_0000, 1'b0, 16'd4};
      tv[4]  = '{1'b1, 32'h1001_000C, 32'h0000_00FF, 32'h0000_0000, 1'b0, 16'd5};
      tv[5]  = '{1'b0, 32'h1001_0004, 32'h0000_0000, 32'h0000_002E, 1'b0, 16'd6};
      tv[6]  = '{1'b0, 32'h1001_0008, 32'h0000_0000, 32'h0000_0020, 1'b0, 16'd7};
      tv[7]  = '{1'b0, 32'h1001_000C, 32'h0000_0000, 32'h0000_00FF, 1'b0, 16'd8};
      tv[8]  = '{1'b0, 32'h1001_0000, 32'h0000_0000, 32'h0000_002C, 1'b0, 16'd9};
      tv[9]  = '{1'b1, 32'h1001_0002, 32'h0000_0055, 32'h0000_0000, 1'b1, 16'd9};
      tv[10] = '{1'b1, 32'h1001_0100, 32'h0000_0077, 32'h0000_0000, 1'b1, 16'd9};
      tv[11] = '{1'b0, 32'h1000_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1, 16'd9};
      tv[12] = '{1'b0, 32'h1001_0000, 32'h0000_0000, 32'h0000_002C, 1'b0, 16'd10};
      tv[13] = '{1'b1, 32'h1001_00FC, 32'h1234_5678, 32'h0000_0000, 1'b0, 16'd11};
      tv[14] = '{1'b0, 32'h1001_00FC, 32'h0000_0000, 32'h1234_5678, 1'b0, 16'd12};
      tv[15] = '{1'b0, 32'h1001_0100, 32'h0000_0000, 32'h0000_0000, 1'b1, 16'd12};
      tv[16] = '{1'b0, 32'h1001_0004, 32'h0000_0000, 32'h0000_002E, 1'b0, 16'd13};

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_outs", {29'd0, rsp_valid, rsp_err, busy}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_count", 32'(access_count), 32'd0);
      reset = 1'b1;

      for (int i = 0; i < 17; i++)
         apply(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].rdata, tv[i].err, tv[i].cnt);

      // back-to-back: req_valid held for 9 edges carrying three loads
      @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = 32'h1001_0004;
      pulses = 0;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k == 0) req_addr = 32'h1001_0008;
         if (k == 3) req_addr = 32'h1001_000C;
         if (k == 8) req_valid = 1'b0;
         chk("b2b_rsp_valid", 32'(rsp_valid), 32'(k == 1 || k == 4 || k == 7));
         chk("b2b_ready", 32'(req_ready), 32'(k == 2 || k == 5 || k >= 8));
         if (rsp_valid) begin
            pulses++;
            chk("b2b_rdata", rsp_rdata, k == 1 ? 32'h2E : k == 4 ? 32'h20 : 32'hFF);
         end
      end
      chk("b2b_pulses", 32'(pulses), 32'd3);
      chk("b2b_count", 32'(access_count), 32'd16);

      // reset during ACCESS of a store must drop it
      @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b1;
      req_addr = 32'h1001_0000;
      req_wdata = 32'hAA;
      @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("abort_ready", {30'd0, req_ready, busy}, 32'd2);
      chk("abort_outs", {30'd0, rsp_valid, rsp_err}, 32'd0);
      chk("abort_rdata", rsp_rdata, 32'd0);
      chk("abort_count", 32'(access_count), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      chk("abort_no_rsp", 32'(pulses), 32'd0);
      apply(1'b0, 32'h1001_0000, 32'h0, 32'h2C, 1'b0, 16'd1);

      // saturation: preset the counter near its ceiling
      @(negedge clk);
      force dut.access_count = 16'hFFFE;
      #1 release dut.access_count;
      apply(1'b0, 32'h1001_0008, 32'h0, 32'h20, 1'b0, 16'hFFFF);
      apply(1'b1, 32'h1001_0010, 32'h5, 32'h0, 1'b0, 16'hFFFF);
      apply(1'b0, 32'h1001_0010, 32'h0, 32'h5, 1'b0, 16'hFFFF);
      apply(1'b0, 32'h1001_0001, 32'h0, 32'h0, 1'b1, 16'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
      $finish;
   end
endmodule
